// File: rtl/div_resta_ctrl_pkg.sv
// Shared types and constants for the restoring divider controller.
package div_pkg;

  // Controller states: waiting, iterating, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/div_resta_ctrl_if.sv
// Execute-stage <-> divider handshake bundle.
interface div_resta_ctrl_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic [3:0]   banderas;

  // Execute stage drives the request and reads back the result.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, banderas
  );

  // Divider consumes the request and drives the result.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, banderas
  );
endinterface

// File: rtl/div_resta_ctrl_step.sv
// One restoring-division step: trial subtract and borrow decision.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   partial,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_rem,
  output logic         qbit
);
  logic [N:0] diff;

  // Single N+1-bit subtractor; a clear top bit means no borrow.
  always_comb begin
    diff     = partial - {1'b0, divisor};
    qbit     = ~diff[N];
    next_rem = qbit ? diff[N-1:0] : partial[N-1:0];
  end
endmodule

// File: rtl/div_resta_ctrl.sv
// Multi-cycle unsigned restoring divider controller, one quotient bit per clock.
module div_resta_ctrl
  import div_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst_n,
  div_resta_ctrl_if.slave bus
);
  div_state_t   state_q;
  logic [N-1:0] dq_q;        // dividend shifting out, quotient shifting in
  logic [N-1:0] rem_q;       // partial remainder
  logic [N-1:0] divisor_q;
  logic [CW-1:0] count_q;
  logic         busy_q;
  logic         done_q;
  logic [N-1:0] quotient_q;
  logic [N-1:0] remainder_q;
  logic [3:0]   banderas_q;

  logic [N:0]   partial_d;
  logic [N-1:0] rem_d;
  logic         qbit_d;
  logic [N-1:0] dq_d;

  assign partial_d = {rem_q, dq_q[N-1]};
  assign dq_d      = {dq_q[N-2:0], qbit_d};

  div_step #(.N(N)) u_step (
    .partial  (partial_d),
    .divisor  (divisor_q),
    .next_rem (rem_d),
    .qbit     (qbit_d)
  );

  // Controller FSM with iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      banderas_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dq_q      <= bus.dividend;
            divisor_q <= bus.divisor;
            rem_q     <= '0;
            count_q   <= '0;
            if (bus.divisor == '0) begin
              // Divide-by-zero finishes at once with the conventional result.
              quotient_q          <= '1;
              remainder_q         <= bus.dividend;
              banderas_q          <= '0;
              banderas_q[FLAG_N]  <= 1'b1;
              banderas_q[FLAG_V]  <= 1'b1;
              done_q              <= 1'b1;
              state_q             <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          dq_q    <= dq_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            quotient_q         <= dq_d;
            remainder_q        <= rem_d;
            banderas_q         <= '0;
            banderas_q[FLAG_N] <= dq_d[N-1];
            banderas_q[FLAG_Z] <= (dq_d == '0);
            busy_q             <= 1'b0;
            done_q             <= 1'b1;
            state_q            <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.banderas  = banderas_q;
endmodule

// File: tb/tb_div_resta_ctrl.sv
// Scoreboard bench for div_resta_ctrl with N=8 directed vectors.
module tb_div_resta_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  typedef struct {
    string    name;
    int       q;
    int       r;
    int       f;
    int       done_at;
    int       busy_cyc;
  } exp_t;

  exp_t sb[$];

  div_resta_ctrl_if #(.N(N)) bus ();

  div_resta_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, " latency"}, cyc, e.done_at);
          chk({e.name, " quotient"}, int'(bus.quotient), e.q);
          chk({e.name, " remainder"}, int'(bus.remainder), e.r);
          chk({e.name, " banderas"}, int'(bus.banderas), e.f);
          chk({e.name, " busy_cycles"}, busy_run, e.busy_cyc);
          $display("op %s: q=%0d r=%0d flags=%b at cycle %0d", e.name,
                   bus.quotient, bus.remainder, bus.banderas, cyc);
        end
        busy_run = 0;
      end
    end
  end

  // Issue one start pulse; optionally record the expected response.
  task automatic issue(input string name, input int a, input int b,
                       input int q, input int r, input int f, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    e.name     = name;
    e.q        = q;
    e.r        = r;
    e.f        = f;
    e.done_at  = cyc + 1 + ((b == 0) ? 0 : N);
    e.busy_cyc = (b == 0) ? 0 : N;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    if (bus.done) seen = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset quotient", int'(bus.quotient), 0);
    chk("reset remainder", int'(bus.remainder), 0);
    chk("reset banderas", int'(bus.banderas), 0);
    rst_n = 1'b1;

    issue("100/7", 100, 7, 14, 2, 4'b0000, 1'b1);     wait_done("100/7");
    issue("5/0", 5, 0, 255, 5, 4'b1001, 1'b1);        wait_done("5/0");
    issue("0/3", 0, 3, 0, 0, 4'b0100, 1'b1);          wait_done("0/3");
    issue("3/9", 3, 9, 0, 3, 4'b0100, 1'b1);          wait_done("3/9");
    issue("0/0", 0, 0, 255, 0, 4'b1001, 1'b1);        wait_done("0/0");
    issue("200/3", 200, 3, 66, 2, 4'b0000, 1'b1);     wait_done("200/3");
    // Back-to-back: second start lands in the IDLE cycle after done.
    issue("255/1", 255, 1, 255, 0, 4'b1000, 1'b1);    wait_done("255/1");
    issue("200/200", 200, 200, 1, 0, 4'b0000, 1'b1);  wait_done("200/200");

    // Start during RUN with changed operands must be ignored.
    issue("50/5", 50, 5, 10, 0, 4'b0000, 1'b1);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd1;
    wait_done("50/5");
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-operation discards the result.
    issue("100/7 aborted", 100, 7, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre-abort busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort quotient", int'(bus.quotient), 0);
    chk("abort remainder", int'(bus.remainder), 0);
    chk("abort banderas", int'(bus.banderas), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("20/6", 20, 6, 3, 2, 4'b0000, 1'b1);        wait_done("20/6");

    repeat (5) @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_resta_ctrl.md
Name: div_resta_ctrl

Overview:
- Multi-cycle unsigned integer divider controller for the CPU ALU.
- Sequences a single shared N+1-bit subtract step through a restoring shift-subtract loop, producing one quotient bit per clock.
- Gives the execute stage a start/busy/done handshake and a 4-bit flag vector in the ALU flag order {N,Z,C,V}.

Parameters:
- N, 32, operand/quotient/remainder width in bits (must be >= 2).
- CW, $clog2(N), iteration counter width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  unsigned dividend, captured when start is accepted.
- divisor  input  N  unsigned divisor, captured when start is accepted.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse, results valid.
- quotient  output  N  result quotient, held until next accepted start.
- remainder  output  N  result remainder, held until next accepted start.
- banderas  output  4  [3]=N (quotient MSB), [2]=Z (quotient==0), [1]=C (always 0), [0]=V (divide-by-zero).

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, banderas=0; internal regs cleared.
  - An in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture dividend and divisor, clear the partial remainder, count=0.
  - If divisor==0, go to DONE; otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN, busy=1:
  - Each edge: partial = {rem[N-1:0], dq[N-1]}, N+1 bits; diff = partial - {1'b0, divisor}.
  - If diff[N]==0 (no borrow): rem=diff[N-1:0] and quotient bit=1; else rem=partial[N-1:0] and quotient bit=0.
  - dq shifts left, inserting the quotient bit at LSB; count increments.
  - At the edge where count==N-1: register quotient, remainder and banderas, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE on the next edge.
  - start is ignored in DONE.
- Latency:
  - Normal: N iterations on edges E1..EN; done high in the cycle after EN, i.e. N+1 cycles after E0.
  - Divide-by-zero: done high in the cycle after E0.
- Divide-by-zero result: quotient = all ones, remainder = captured dividend, V=1, N=1, Z=0.
- Flags for a normal result: V=0, C=0; N and Z come from the final quotient.
- start while busy or done: ignored; no capture and no effect on the running operation.
- Operand changes after E0 have no effect.
- Outputs are registered; no combinational path from inputs to outputs.
- Back-to-back: next start is accepted in the IDLE cycle following DONE, giving a minimum start-to-start spacing of N+2 cycles.

Decomposition:
- Package div_pkg:
  - enum typedef div_state_t {IDLE, RUN, DONE}.
  - Flag index localparams: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module div_step (combinational):
  - Inputs: partial [N:0], divisor [N-1:0].
  - Outputs: next_rem [N-1:0], qbit.
  - Contains the single N+1-bit subtractor and borrow decision, shared across all iterations.
- Top holds the FSM, counter, dq/rem shift registers and result/flag registers.

Test Plan:
- N=8, dividend=100, divisor=7, start pulsed 1 cycle -> busy high 8 cycles, done pulse 9 cycles after E0; quotient=14, remainder=2, banderas=4'b0000.
- N=8, 5/0 -> done in cycle after E0; quotient=8'hFF, remainder=5, banderas=4'b1001; busy never asserted.
- N=8, 0/3 -> quotient=0, remainder=0, banderas=4'b0100; also 3/9 -> quotient=0, remainder=3, Z=1.
- N=8, 255/1 -> quotient=255, remainder=0, banderas=4'b1000; then immediately 200/200 -> quotient=1, remainder=0.
- Start 50/5 then, during RUN, pulse start with 9/3 and change operands -> result stays quotient=10, remainder=0; exactly one done pulse.
- Start 100/7, drop rst_n low at iteration 4 -> all outputs 0 asynchronously, no done. After release, start 20/6 -> quotient=3, remainder=2 with normal latency.
